// File: rtl/mc_boot_sequencer.sv
// Supervisory loader/run controller for an MC14500B core: streams a program into instruction memory, then runs/steps/halts the core.
// Each accepted word is written exactly one cycle after its handshake; in_ready is high only while loading.
module mc_boot_sequencer #(
    parameter int ADDR    = 8,
    parameter int CODE    = 4,
    parameter int WORD    = ADDR + CODE,
    parameter int CNT_W   = 16,
    parameter int MAX_RUN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_data,
    input  logic             in_last,
    input  logic             start,
    input  logic             step,
    input  logic             halt,
    output logic             program_write,
    output logic [WORD-1:0]  program_cmd,
    output logic [ADDR-1:0]  prog_addr,
    output logic             core_rst,
    output logic             core_en,
    output logic [2:0]       state,
    output logic [ADDR:0]    load_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             trunc_err,
    output logic             timeout
);

    localparam int               LC_W      = ADDR + 1;
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_RUN);
    localparam bit               LIMITED   = (MAX_RUN != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               program_write_q, program_write_d;
    logic [WORD-1:0]    program_cmd_q, program_cmd_d;
    logic [ADDR-1:0]    prog_addr_q, prog_addr_d;
    logic [LC_W-1:0]    load_count_q, load_count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               trunc_err_q, trunc_err_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            program_write_q <= 1'b0;
            program_cmd_q   <= '0;
            prog_addr_q     <= '0;
            load_count_q    <= '0;
            cycle_count_q   <= '0;
            trunc_err_q     <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            program_write_q <= program_write_d;
            program_cmd_q   <= program_cmd_d;
            prog_addr_q     <= prog_addr_d;
            load_count_q    <= load_count_d;
            cycle_count_q   <= cycle_count_d;
            trunc_err_q     <= trunc_err_d;
            timeout_q       <= timeout_d;
        end
    end

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    assign cnt_inc   = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    assign last_addr = (load_count_q[ADDR-1:0] == '1);

    always_comb begin
        state_d         = state_q;
        program_write_d = 1'b0;
        program_cmd_d   = program_cmd_q;
        prog_addr_d     = prog_addr_q;
        load_count_d    = load_count_q;
        cycle_count_d   = cycle_count_q;
        trunc_err_d     = trunc_err_q;
        timeout_d       = timeout_q;

        if (load_req && (state_q != S_LOAD)) begin
            state_d      = S_LOAD;
            load_count_d = '0;
            trunc_err_d  = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        program_write_d = 1'b1;
                        program_cmd_d   = in_data;
                        prog_addr_d     = load_count_q[ADDR-1:0];
                        load_count_d    = load_count_q + LC_W'(1);
                        if (in_last) begin
                            state_d = S_ARMED;
                        end else if (last_addr) begin
                            // Memory full without a terminator: stop rather than wrap.
                            state_d     = S_ARMED;
                            trunc_err_d = 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (step) begin
                        state_d       = S_STEP;
                        cycle_count_d = '0;
                    end else if (start) begin
                        state_d       = S_RUN;
                        cycle_count_d = '0;
                    end
                end
                S_RUN: begin
                    cycle_count_d = cnt_inc;
                    if (halt) begin
                        state_d = S_HALT;
                    end
                    if (LIMITED && (cnt_inc >= RUN_LIMIT)) begin
                        state_d   = S_HALT;
                        timeout_d = 1'b1;
                    end
                end
                S_STEP: begin
                    cycle_count_d = cnt_inc;
                    state_d       = S_HALT;
                end
                S_HALT: begin
                    if (step) begin
                        state_d = S_STEP;
                    end else if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == S_LOAD);
    // HALT keeps the core out of reset so its registers survive between runs.
    assign core_rst      = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_ARMED);
    assign core_en       = (state_q == S_RUN) || (state_q == S_STEP);
    assign state         = state_q;
    assign program_write = program_write_q;
    assign program_cmd   = program_cmd_q;
    assign prog_addr     = prog_addr_q;
    assign load_count    = load_count_q;
    assign cycle_count   = cycle_count_q;
    assign trunc_err     = trunc_err_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_mc_boot_sequencer.sv
// Bench for mc_boot_sequencer: a default instance (a_) and a small instance with ADDR=4, MAX_RUN=5 (b_).
module tb_mc_boot_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int cmd;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];

    // instance a: ADDR=8, WORD=12, unlimited run
    logic        a_load_req = 0, a_in_valid = 0, a_in_last = 0, a_start = 0, a_step = 0, a_halt = 0;
    logic [11:0] a_in_data = '0;
    logic        a_in_ready, a_program_write, a_core_rst, a_core_en, a_trunc_err, a_timeout;
    logic [11:0] a_program_cmd;
    logic [7:0]  a_prog_addr;
    logic [2:0]  a_state;
    logic [8:0]  a_load_count;
    logic [15:0] a_cycle_count;

    // instance b: ADDR=4, WORD=8, run limit 5
    logic        b_load_req = 0, b_in_valid = 0, b_in_last = 0, b_start = 0, b_step = 0, b_halt = 0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready, b_program_write, b_core_rst, b_core_en, b_trunc_err, b_timeout;
    logic [7:0]  b_program_cmd;
    logic [3:0]  b_prog_addr;
    logic [2:0]  b_state;
    logic [4:0]  b_load_count;
    logic [15:0] b_cycle_count;

    mc_boot_sequencer u_a (
        .clk(clk), .rst(rst), .load_req(a_load_req), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .start(a_start), .step(a_step), .halt(a_halt),
        .program_write(a_program_write), .program_cmd(a_program_cmd), .prog_addr(a_prog_addr),
        .core_rst(a_core_rst), .core_en(a_core_en), .state(a_state), .load_count(a_load_count),
        .cycle_count(a_cycle_count), .trunc_err(a_trunc_err), .timeout(a_timeout)
    );

    mc_boot_sequencer #(.ADDR(4), .MAX_RUN(5)) u_b (
        .clk(clk), .rst(rst), .load_req(b_load_req), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .start(b_start), .step(b_step), .halt(b_halt),
        .program_write(b_program_write), .program_cmd(b_program_cmd), .prog_addr(b_prog_addr),
        .core_rst(b_core_rst), .core_en(b_core_en), .state(b_state), .load_count(b_load_count),
        .cycle_count(b_cycle_count), .trunc_err(b_trunc_err), .timeout(b_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port monitors: every strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (!rst && a_program_write) begin
            if (qa.size() == 0) begin
                chk("a_wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = qa.pop_front();
                chk("a_wr_cycle", cyc, e.cyc);
                chk("a_wr_addr", {24'd0, a_prog_addr}, e.addr);
                chk("a_wr_cmd", {20'd0, a_program_cmd}, e.cmd);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_program_write) begin
            if (qb.size() == 0) begin
                chk("b_wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = qb.pop_front();
                chk("b_wr_cycle", cyc, e.cyc);
                chk("b_wr_addr", {28'd0, b_prog_addr}, e.addr);
                chk("b_wr_cmd", {24'd0, b_program_cmd}, e.cmd);
            end
        end
    end

    // Caller is just after a rising edge; the word is offered for one cycle.
    task automatic send_a(input logic [11:0] w, input logic lst, input int idx, input logic exp_rdy);
        a_in_valid = 1'b1;
        a_in_data  = w;
        a_in_last  = lst;
        @(negedge clk);
        chk("a_in_ready", a_in_ready, exp_rdy);
        if (exp_rdy) qa.push_back('{cyc + 1, idx, int'(w)});
        tick();
    endtask

    task automatic send_b(input logic [7:0] w, input logic lst, input int idx, input logic exp_rdy);
        b_in_valid = 1'b1;
        b_in_data  = w;
        b_in_last  = lst;
        @(negedge clk);
        chk("b_in_ready", b_in_ready, exp_rdy);
        if (exp_rdy) qb.push_back('{cyc + 1, idx, int'(w)});
        tick();
    endtask

    logic [11:0] prog1 [3];

    initial begin
        prog1[0] = 12'h1A0;
        prog1[1] = 12'h2FF;
        prog1[2] = 12'h305;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", a_state, 3'd0);
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_pw", a_program_write, 1'b0);
        chk("rst_cmd", a_program_cmd, 12'h0);
        chk("rst_addr", a_prog_addr, 8'h0);
        chk("rst_core_rst", a_core_rst, 1'b1);
        chk("rst_core_en", a_core_en, 1'b0);
        chk("rst_load_count", a_load_count, 9'd0);
        chk("rst_cycle_count", a_cycle_count, 16'd0);
        chk("rst_trunc", a_trunc_err, 1'b0);
        chk("rst_timeout", a_timeout, 1'b0);
        tick();
        rst = 1'b0;

        // three-word load ending with in_last
        tick();
        a_load_req = 1'b1;
        tick();
        a_load_req = 1'b0;
        for (int i = 0; i < 3; i++) send_a(prog1[i], (i == 2), i, 1'b1);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        @(negedge clk);
        chk("t1_load_count", a_load_count, 9'd3);
        chk("t1_state", a_state, 3'd2);
        chk("t1_trunc", a_trunc_err, 1'b0);
        chk("t1_in_ready", a_in_ready, 1'b0);
        chk("t1_core_rst", a_core_rst, 1'b1);
        chk("t1_core_en", a_core_en, 1'b0);
        tick();
        chk("t1_drained", qa.size(), 0);

        // start, halt after 10 run cycles
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) a_halt = 1'b1;
            @(negedge clk);
            chk("t3_core_en", a_core_en, 1'b1);
            chk("t3_core_rst", a_core_rst, 1'b0);
            chk("t3_state", a_state, 3'd3);
            tick();
            a_halt = 1'b0;
        end
        @(negedge clk);
        chk("t3_halt_state", a_state, 3'd5);
        chk("t3_halt_en", a_core_en, 1'b0);
        chk("t3_halt_rst", a_core_rst, 1'b0);
        chk("t3_cycle_count", a_cycle_count, 16'd10);

        // three single steps from HALT
        for (int k = 0; k < 3; k++) begin
            tick();
            a_step = 1'b1;
            tick();
            a_step = 1'b0;
            @(negedge clk);
            chk("t4_step_state", a_state, 3'd4);
            chk("t4_step_en", a_core_en, 1'b1);
            tick();
            @(negedge clk);
            chk("t4_back_state", a_state, 3'd5);
            chk("t4_back_en", a_core_en, 1'b0);
            chk("t4_cycle_count", a_cycle_count, 16'(11 + k));
        end

        // 17 words into 16-deep memory, no terminator
        tick();
        b_load_req = 1'b1;
        tick();
        b_load_req = 1'b0;
        for (int i = 0; i < 17; i++) send_b(8'($urandom_range(0, 255)), 1'b0, i, (i < 16));
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("t2_trunc", b_trunc_err, 1'b1);
        chk("t2_load_count", b_load_count, 5'd16);
        chk("t2_state", b_state, 3'd2);
        chk("t2_in_ready", b_in_ready, 1'b0);
        tick();
        chk("t2_drained", qb.size(), 0);

        // run limit of 5 cycles
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("t5_core_en", b_core_en, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("t5_core_en_off", b_core_en, 1'b0);
        chk("t5_timeout", b_timeout, 1'b1);
        chk("t5_state", b_state, 3'd5);
        chk("t5_cycle_count", b_cycle_count, 16'd5);
        tick();
        b_load_req = 1'b1;
        tick();
        b_load_req = 1'b0;
        @(negedge clk);
        chk("t5_reload_timeout", b_timeout, 1'b0);
        chk("t5_reload_core_rst", b_core_rst, 1'b1);
        chk("t5_reload_state", b_state, 3'd1);

        // reset on the cycle a write strobe is active
        tick();
        a_load_req = 1'b1;
        tick();
        a_load_req = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 12'hABC;
        a_in_last  = 1'b0;
        @(posedge clk);
        #2;
        chk("t6_pw_before", a_program_write, 1'b1);
        rst = 1'b1;
        a_in_valid = 1'b0;
        #1;
        chk("t6_pw_rst", a_program_write, 1'b0);
        chk("t6_state_rst", a_state, 3'd0);
        chk("t6_core_rst", a_core_rst, 1'b1);
        chk("t6_in_ready", a_in_ready, 1'b0);
        chk("t6_load_count", a_load_count, 9'd0);
        qa.delete();
        qb.delete();
        tick();
        rst = 1'b0;

        // reset while running
        tick();
        a_load_req = 1'b1;
        tick();
        a_load_req = 1'b0;
        send_a(12'h7E1, 1'b1, 0, 1'b1);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("t6_run_en", a_core_en, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_run_state", a_state, 3'd0);
        chk("t6_run_core_rst", a_core_rst, 1'b1);
        chk("t6_run_core_en", a_core_en, 1'b0);
        chk("t6_run_cycle_count", a_cycle_count, 16'd0);
        chk("t6_run_pw", a_program_write, 1'b0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
